// File: rtl/pulse_gate.sv
// pulse_gate: trigger-synchronised gate forwarding a delayed window of AXI-Stream beats per pulse,
// with pulse/miss counters and a sticky overrun flag.
module pulse_gate #(
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       trig,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  input  logic                       enable,
  input  logic [15:0]                delay,
  input  logic [15:0]                n_samples,
  input  logic                       status_clr,
  output logic [31:0]                pulse_count,
  output logic [15:0]                trig_miss,
  output logic                       overrun
);
  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE} state_t;
  state_t r_state, w_state;
  logic r_trig_s1, r_trig_s2, r_trig_s3, r_trig_edge;
  logic [15:0] r_delay, r_nsamp, r_cnt, r_trig_miss;
  logic [15:0] w_delay, w_nsamp, w_cnt, w_cnt_inc;
  logic [AXIS_DATA_WIDTH-1:0] r_m_tdata;
  logic r_m_tvalid, r_m_tlast, r_overrun;
  logic [31:0] r_pulse_count;
  logic w_start, w_emit, w_done, w_dly_done, w_miss, w_ov_set;
  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign pulse_count   = r_pulse_count;
  assign trig_miss     = r_trig_miss;
  assign overrun       = r_overrun;
  // The beat arriving with the accepted edge is processed as if the new state were already in force
  assign w_start    = r_state == IDLE && r_trig_edge && enable && n_samples != 16'd0;
  assign w_state    = w_start ? (delay != 16'd0 ? DELAY : CAPTURE) : r_state;
  assign w_delay    = w_start ? delay : r_delay;
  assign w_nsamp    = w_start ? n_samples : r_nsamp;
  assign w_cnt      = w_start ? 16'd0 : r_cnt;
  assign w_cnt_inc  = w_cnt + 16'd1;
  assign w_emit     = w_state == CAPTURE && s_axis_tvalid;
  assign w_done     = w_emit && w_cnt_inc == w_nsamp;
  assign w_dly_done = w_state == DELAY && s_axis_tvalid && w_cnt_inc == w_delay;
  assign w_miss     = r_trig_edge && r_state != IDLE;
  assign w_ov_set   = r_m_tvalid && !m_axis_tready;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= IDLE;
      r_trig_s1     <= 1'b0;
      r_trig_s2     <= 1'b0;
      r_trig_s3     <= 1'b0;
      r_trig_edge   <= 1'b0;
      r_delay       <= '0;
      r_nsamp       <= '0;
      r_cnt         <= '0;
      r_m_tdata     <= '0;
      r_m_tvalid    <= 1'b0;
      r_m_tlast     <= 1'b0;
      r_pulse_count <= '0;
      r_trig_miss   <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_trig_s1   <= trig;
      r_trig_s2   <= r_trig_s1;
      r_trig_s3   <= r_trig_s2;
      r_trig_edge <= r_trig_s2 & ~r_trig_s3;
      if (w_start) begin
        r_delay <= delay;
        r_nsamp <= n_samples;
      end
      r_state    <= w_done ? IDLE : w_dly_done ? CAPTURE : w_state;
      r_cnt      <= (w_done || w_dly_done) ? 16'd0 : (s_axis_tvalid && w_state != IDLE) ? w_cnt_inc : w_cnt;
      r_m_tvalid <= w_emit;
      r_m_tlast  <= w_done;
      if (w_emit) r_m_tdata <= s_axis_tdata;
      // A same-cycle event wins over status_clr
      r_pulse_count <= status_clr ? 32'(w_done) : r_pulse_count + 32'(w_done);
      r_trig_miss   <= status_clr ? 16'(w_miss) : (w_miss && r_trig_miss != 16'hFFFF) ? r_trig_miss + 16'd1 : r_trig_miss;
      r_overrun     <= w_ov_set | (r_overrun & ~status_clr);
    end
  end
endmodule

// File: tb/tb_pulse_gate.sv
// tb_pulse_gate: directed self-checking bench for pulse_gate.
module tb_pulse_gate;
  logic        aclk = 1'b0, aresetn = 1'b0, trig = 1'b0, s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b1, enable = 1'b0, status_clr = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [15:0] delay = '0, n_samples = '0;
  logic        s_axis_tready, m_axis_tvalid, m_axis_tlast, overrun;
  logic [31:0] m_axis_tdata, pulse_count;
  logic [15:0] trig_miss;
  int k = 0, j = 0, n_chk = 0, n_pass = 0, n_fail = 0, lat_err = 0;
  int j1, j2, j3, j4, j6, j7, qn;
  bit tog = 1'b0;
  logic [31:0] q_data[$];
  logic        q_last[$];

  always #5 aclk = ~aclk;

  pulse_gate #(.AXIS_DATA_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .trig(trig),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .enable(enable), .delay(delay), .n_samples(n_samples),
    .status_clr(status_clr), .pulse_count(pulse_count), .trig_miss(trig_miss), .overrun(overrun)
  );

  // Input beat with data d is sampled one edge after it is driven, so its output must carry k-1
  always @(negedge aclk)
    if (m_axis_tvalid) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
      if (m_axis_tdata !== 32'(k - 1)) lat_err++;
    end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
      k++;
      s_axis_tdata  = 32'(k);
      s_axis_tvalid = tog ? k[0] : 1'b1;
    end
  endtask

  // trig rises alongside data j; the synchronised edge coincides with input beat j+3
  task automatic fire();
    trig = 1'b1;
    j = k;
    step(2);
    trig = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lastvec();
    logic [31:0] v = '0;
    foreach (q_last[i]) if (i < 32) v[i] = q_last[i];
    return v;
  endfunction

  task automatic qclr();
    q_data.delete();
    q_last.delete();
  endtask

  initial begin
    step(3);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_pulse_count", pulse_count, 0);
    chk("rst_trig_miss", 32'(trig_miss), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("s_tready", 32'(s_axis_tready), 1);
    aresetn = 1'b1;
    enable = 1'b1;
    delay = 16'd2;
    n_samples = 16'd4;
    step(4);

    qclr();
    fire();
    j1 = j;
    step(12);
    chk("t1_count", 32'(q_data.size()), 4);
    for (int i = 0; i < 4; i++) chk("t1_data", q_data[i], 32'(j1 + 5 + i));
    chk("t1_tlast", lastvec(), 32'h8);
    chk("t1_pulse_count", pulse_count, 1);
    chk("t1_trig_miss", 32'(trig_miss), 0);

    tog = 1'b1;
    delay = 16'd0;
    n_samples = 16'd3;
    step(2);
    if (k % 2 != 0) step(1);
    qclr();
    fire();
    j2 = j;
    step(12);
    chk("t2_count", 32'(q_data.size()), 3);
    for (int i = 0; i < 3; i++) chk("t2_data", q_data[i], 32'(j2 + 3 + 2 * i));
    chk("t2_tlast", lastvec(), 32'h4);
    chk("t2_pulse_count", pulse_count, 2);

    tog = 1'b0;
    n_samples = 16'd8;
    step(2);
    qclr();
    fire();
    j3 = j;
    step(2);
    fire();
    step(20);
    chk("t3_count", 32'(q_data.size()), 8);
    chk("t3_first", q_data[0], 32'(j3 + 3));
    chk("t3_last_data", q_data[7], 32'(j3 + 10));
    chk("t3_tlast", lastvec(), 32'h80);
    chk("t3_trig_miss", 32'(trig_miss), 1);
    chk("t3_pulse_count", pulse_count, 3);
    fire();
    j4 = j;
    step(20);
    chk("t3_second_count", 32'(q_data.size()), 16);
    chk("t3_second_first", q_data[8], 32'(j4 + 3));
    chk("t3_second_pulse_count", pulse_count, 4);

    n_samples = 16'd2;
    chk("t4_overrun_pre", 32'(overrun), 0);
    fire();
    step(2);
    m_axis_tready = 1'b0;
    step(1);
    m_axis_tready = 1'b1;
    step(10);
    chk("t4_overrun", 32'(overrun), 1);
    chk("t4_pulse_count", pulse_count, 5);
    status_clr = 1'b1;
    step(1);
    status_clr = 1'b0;
    chk("t4_clr_pulse_count", pulse_count, 0);
    chk("t4_clr_overrun", 32'(overrun), 0);
    chk("t4_clr_trig_miss", 32'(trig_miss), 0);
    n_samples = 16'd1;
    step(2);
    fire();
    step(1);
    status_clr = 1'b1;
    step(1);
    status_clr = 1'b0;
    chk("t4_clr_priority", pulse_count, 1);
    step(5);

    enable = 1'b0;
    n_samples = 16'd4;
    qn = q_data.size();
    fire();
    step(10);
    chk("t5_disabled_count", 32'(q_data.size()), 32'(qn));
    chk("t5_disabled_trig_miss", 32'(trig_miss), 0);
    chk("t5_disabled_pulse_count", pulse_count, 1);
    enable = 1'b1;
    n_samples = 16'd0;
    fire();
    step(10);
    chk("t5_zero_count", 32'(q_data.size()), 32'(qn));
    chk("t5_zero_pulse_count", pulse_count, 1);

    delay = 16'd1;
    n_samples = 16'd4;
    qclr();
    fire();
    j6 = j;
    step(2);
    enable = 1'b0;
    delay = 16'd9;
    n_samples = 16'd1;
    step(12);
    chk("t6_count", 32'(q_data.size()), 4);
    chk("t6_first", q_data[0], 32'(j6 + 4));
    chk("t6_tlast", lastvec(), 32'h8);
    chk("t6_pulse_count", pulse_count, 2);
    enable = 1'b1;

    delay = 16'd0;
    n_samples = 16'd8;
    qclr();
    fire();
    step(3);
    aresetn = 1'b0;
    step(1);
    chk("t7_rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("t7_rst_tlast", 32'(m_axis_tlast), 0);
    chk("t7_rst_tdata", m_axis_tdata, 0);
    chk("t7_rst_pulse_count", pulse_count, 0);
    aresetn = 1'b1;
    step(15);
    chk("t7_aborted_count", 32'(q_data.size()), 2);
    chk("t7_aborted_tlast", lastvec(), 0);
    fire();
    j7 = j;
    step(15);
    chk("t7_resume_count", 32'(q_data.size()), 10);
    chk("t7_resume_first", q_data[2], 32'(j7 + 3));
    chk("t7_resume_tlast", lastvec(), 32'h200);
    chk("t7_resume_pulse_count", pulse_count, 1);

    chk("latency", 32'(lat_err), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pulse_gate.md
PULSE_GATE -- requirements
Module: pulse_gate

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 32, width of sample data on both stream ports.
REQ-002 SHALL have port aclk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port trig  input  1  asynchronous pulse-start trigger (chirp sync).
REQ-005 SHALL have port s_axis_tdata  input  AXIS_DATA_WIDTH  ADC sample.
REQ-006 SHALL have port s_axis_tvalid  input  1  sample valid.
REQ-007 SHALL have port s_axis_tready  output  1  constant 1; block never stalls source.
REQ-008 SHALL have port m_axis_tdata  output  AXIS_DATA_WIDTH  gated sample to pulse integrator.
REQ-009 SHALL have port m_axis_tvalid  output  1  gated sample valid.
REQ-010 SHALL have port m_axis_tlast  output  1  marks final sample of a pulse.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready; observed for overrun only.
REQ-012 SHALL have port enable  input  1  arm trigger acceptance.
REQ-013 SHALL have port delay  input  16  valid samples skipped after trigger.
REQ-014 SHALL have port n_samples  input  16  samples emitted per pulse.
REQ-015 SHALL have port status_clr  input  1  single-cycle clear of all status outputs.
REQ-016 SHALL have port pulse_count  output  32  completed pulses, wraps at 2^32.
REQ-017 SHALL have port trig_miss  output  16  triggers ignored while busy, saturates at 0xFFFF.
REQ-018 SHALL have port overrun  output  1  sticky: beat emitted while m_axis_tready low.

Function
REQ-019 SHALL pass trig through a 2-flop synchronizer and a rising-edge detector; trig_edge asserts exactly 3 cycles after trig rises (trig setup to aclk met), one cycle wide.
REQ-020 SHALL implement states IDLE, DELAY, CAPTURE; reset state IDLE.
REQ-021 IDLE: on trig_edge with enable=1, SHALL latch delay and n_samples into internal registers, clear beat counter, go to DELAY if latched delay>0, else CAPTURE; trig_edge with enable=0 SHALL be ignored and not counted.
REQ-022 IDLE with latched n_samples=0 SHALL instead remain in IDLE, emit nothing, not increment pulse_count.
REQ-023 DELAY: SHALL count s_axis_tvalid beats only; on the beat bringing count to latched delay, clear counter and go to CAPTURE; that beat SHALL NOT be emitted.
REQ-024 CAPTURE: each s_axis_tvalid beat SHALL be emitted; on beat number n_samples, SHALL assert tlast with it, increment pulse_count, go to IDLE.
REQ-025 Output SHALL be registered: m_axis_tdata/tvalid/tlast appear exactly 1 cycle after the accepted input beat; tvalid high for one cycle per beat.
REQ-026 The first valid beat in the cycle trig_edge is asserted SHALL be treated as already in the new state (delay=0: emitted as sample 1).
REQ-027 trig_edge in DELAY or CAPTURE SHALL be ignored for gating and SHALL increment trig_miss (saturating).
REQ-028 Deassertion of enable in DELAY or CAPTURE SHALL NOT abort; current pulse completes, then no new trigger is accepted.
REQ-029 Config changes after latch SHALL not affect the pulse in progress.
REQ-030 overrun SHALL set on any cycle m_axis_tvalid=1 and m_axis_tready=0; beat is not retained or retried.
REQ-031 status_clr SHALL zero pulse_count, trig_miss, overrun next cycle; a same-cycle increment/set event SHALL take priority (counter becomes 1 / overrun stays 1).
REQ-032 Counters SHALL be 16-bit for delay/beat, comparisons unsigned.

Reset
REQ-033 On aresetn=0, SHALL drive state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, pulse_count=0, trig_miss=0, overrun=0, synchronizer flops=0.
REQ-034 Reset asserted mid-CAPTURE SHALL abort the pulse with no tlast; first pulse after reset requires a fresh trig rising edge.

Verification
REQ-035 delay=2, n_samples=4, continuous valid data 0,1,2,...: trig -> samples 2..5 emitted (relative to beat at edge), tlast on 4th, pulse_count=1.
REQ-036 delay=0, n_samples=3, tvalid toggling every other cycle -> exactly 3 beats emitted, each 1 cycle after input beat, tlast on 3rd.
REQ-037 n_samples=8, second trig during CAPTURE -> 8 beats only, trig_miss=1, pulse_count=1; trig after completion -> second pulse.
REQ-038 m_axis_tready=0 during one emitted beat -> overrun=1; status_clr -> overrun=0, pulse_count=0 next cycle.
REQ-039 enable=0 at trig -> no output, trig_miss=0; n_samples=0 with enable=1 -> no output, pulse_count unchanged.
REQ-040 aresetn low at CAPTURE beat 3 of 8 -> outputs zero next cycle, no tlast, resumes only on new trig.
